// File: rtl/fft_cmul_scheduler_if.sv
// Sample-in / twiddled-sample-out handshake bundle for the FFT stage twiddle scheduler.
interface fft_cmul_scheduler_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_real;
    logic signed [31:0] in_imag;
    logic [2:0]         tw_step;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_real;
    logic signed [31:0] out_imag;
    logic [2:0]         out_idx;
    logic               out_last;

    modport master (
        output in_valid, in_real, in_imag, tw_step, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_real, in_imag, tw_step, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_idx, out_last
    );
endinterface

// File: rtl/fft_cmul_scheduler.sv
// Collects an 8-sample frame, applies W8^(k*tw_step) through one registered Q24.8
// complex multiplier, then streams the twiddled frame out.
module fft_cmul_scheduler #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    output logic                 busy,
    fft_cmul_scheduler_if.slave  bus
);
    localparam logic [2:0] LAST = 3'(FRAME_LEN - 1);

    typedef enum logic [1:0] {LOAD, MUL, UNLOAD} state_t;
    state_t state, state_nxt;

    logic [2:0]         cnt, iss, pidx, j, tw_lat;
    logic               issuing, pv;
    logic signed [31:0] buf_re [8];
    logic signed [31:0] buf_im [8];
    logic signed [31:0] res_re [8];
    logic signed [31:0] res_im [8];
    logic signed [31:0] prod_re, prod_im;
    logic signed [31:0] src_re, src_im;
    logic               accept, last_accept, prod_en, out_v, out_hs;
    logic [2:0]         mi, e;
    logic signed [63:0] a, b, c, d, sum_re, sum_im;

    assign accept      = bus.in_valid && (state == LOAD);
    assign last_accept = accept && (cnt == LAST);
    assign out_hs      = out_v && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        out_v        = 1'b0;
        busy         = 1'b0;
        case (state)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (last_accept) state_nxt = MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (pv && pidx == LAST) state_nxt = UNLOAD;
            end
            UNLOAD: begin
                busy  = 1'b1;
                out_v = 1'b1;
                if (out_hs && j == LAST) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
        if (flush) state_nxt = LOAD;
    end

    assign bus.out_valid = out_v;
    assign bus.out_idx   = j;
    assign bus.out_last  = out_v && (j == LAST);
    assign bus.out_real  = out_v ? res_re[j] : '0;
    assign bus.out_imag  = out_v ? res_im[j] : '0;

    // Index 0 is issued on the final load edge so the pipeline drains within 8 MUL cycles.
    assign mi      = (state == MUL) ? iss : '0;
    assign e       = mi * tw_lat;
    assign prod_en = last_accept || (state == MUL && issuing);
    assign src_re  = buf_re[mi];
    assign src_im  = buf_im[mi];

    always_comb begin
        c = '0;
        d = '0;
        case (e)
            3'd0: begin c =  64'sd256; d =  64'sd0;   end
            3'd1: begin c =  64'sd181; d = -64'sd181; end
            3'd2: begin c =  64'sd0;   d = -64'sd256; end
            3'd3: begin c = -64'sd181; d = -64'sd181; end
            3'd4: begin c = -64'sd256; d =  64'sd0;   end
            3'd5: begin c = -64'sd181; d =  64'sd181; end
            3'd6: begin c =  64'sd0;   d =  64'sd256; end
            default: begin c = 64'sd181; d = 64'sd181; end
        endcase
    end

    assign a      = {{32{src_re[31]}}, src_re};
    assign b      = {{32{src_im[31]}}, src_im};
    assign sum_re = a * c - b * d;
    assign sum_im = a * d + b * c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            iss     <= '0;
            pidx    <= '0;
            j       <= '0;
            tw_lat  <= '0;
            issuing <= 1'b0;
            pv      <= 1'b0;
        end else if (flush) begin
            cnt     <= '0;
            iss     <= '0;
            pidx    <= '0;
            j       <= '0;
            issuing <= 1'b0;
            pv      <= 1'b0;
        end else begin
            if (accept) begin
                if (cnt == '0) tw_lat <= bus.tw_step;
                cnt <= cnt + 3'd1;
            end
            if (last_accept) begin
                issuing <= 1'b1;
                iss     <= 3'd1;
                pidx    <= '0;
                pv      <= 1'b1;
            end else if (state == MUL) begin
                pv <= issuing;
                if (issuing) begin
                    pidx <= iss;
                    iss  <= iss + 3'd1;
                    if (iss == LAST) issuing <= 1'b0;
                end
            end
            if (out_hs) j <= j + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_re[cnt] <= bus.in_real;
            buf_im[cnt] <= bus.in_imag;
        end
        if (prod_en) begin
            prod_re <= 32'(sum_re >>> FRAC_BITS);
            prod_im <= 32'(sum_im >>> FRAC_BITS);
        end
        if (pv && state == MUL) begin
            res_re[pidx] <= prod_re;
            res_im[pidx] <= prod_im;
        end
    end
endmodule

// File: doc/fft_cmul_scheduler.md
# fft_cmul_scheduler

Frame-based scheduler that time-shares one Q24.8 complex multiplier across the 8 samples of an FFT stage. Collects 8 complex samples, then multiplies sample k by twiddle W8^((k·tw_step) mod 8) at one issue per cycle through a single registered multiplier. Streams the 8 results out with a valid/ready handshake. Sits between butterfly stages of the 8-point FFT and holds the twiddle ROM for the stage.

## Interface
- FRAME_LEN, 8, samples per frame; fixed at 8, no other value supported
- FRAC_BITS, 8, fractional bits of the Q24.8 data and twiddle format
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort; frame discarded, return to LOAD
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts a sample this cycle
- in_real, in_imag  in  32 signed  input sample, Q24.8
- tw_step  in  3  twiddle step, sampled with the first sample of a frame
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the output
- out_real, out_imag  out  32 signed  twiddled sample, Q24.8
- out_idx  out  3  index k of the current output
- out_last  out  1  high with k = 7
- busy  out  1  high in MUL and UNLOAD states

## Operation
- FSM states:
  - LOAD: in_ready = 1, load counter 0..7. A sample is accepted on in_valid & in_ready and written to input buffer[cnt]. tw_step is latched when cnt = 0. After the 8th accept, go to MUL.
  - MUL: issue index i = 0..7, one per cycle, with no stalls. Product is registered, then written to result buffer[i] one edge later. Go to UNLOAD on the edge that writes result[7].
  - UNLOAD: out_valid = 1, presenting result[j] with out_idx = j. Advance j on out_valid & out_ready. After the handshake with j = 7, go to LOAD with cnt = 0.
- Twiddle ROM (re, im) for exponent e = 0..7:
  - e0 (256, 0), e1 (181, -181), e2 (0, -256), e3 (-181, -181)
  - e4 (-256, 0), e5 (-181, 181), e6 (0, 256), e7 (181, 181)
  - e = (k·tw_step) mod 8, computed as the low 3 bits of the product.
- Arithmetic for sample (a, b) and twiddle (c, d):
  - re = (a·c − b·d) >>> 8, im = (a·d + b·c) >>> 8.
  - Products and sums use a 64-bit signed intermediate; arithmetic shift, i.e. floor, no rounding.
  - Result is the low 32 bits; overflow wraps, no saturation.
- flush: has priority over every other event in every state. Next state is LOAD with all counters 0 and out_valid = 0. Buffer contents are don't-care.
- In LOAD, in_valid with in_ready low cannot occur, because in_ready is high throughout LOAD.
- Inputs presented during MUL or UNLOAD are not accepted (in_ready = 0). The upstream block holds them.
- Output data are stable while out_valid & !out_ready.

## Timing
- Reset values:
  - state LOAD; in_ready 1; out_valid 0; out_real, out_imag 0; out_idx 0; out_last 0; busy 0.
  - all counters 0; latched tw_step 0.
- Reset asserted mid-frame: the frame is aborted immediately (asynchronous). Outputs take their reset values in the same cycle.
- Load phase takes a minimum of 8 cycles; gaps in in_valid are allowed.
- Latency: out_valid rises 8 cycles after the edge that accepts the 8th sample. With out_ready held high, the 8 outputs take 8 consecutive cycles.
- in_ready rises in the cycle after the handshake of out_idx = 7.
- Minimum frame period is 24 cycles.
- out_last = out_valid & (out_idx == 7).

## Test plan
- Identity: tw_step = 0, samples k = (k·256, −k·256). Outputs must equal the inputs exactly, out_idx 0..7, out_last only on k = 7, out_valid 8 cycles after the 8th accept.
- Twiddle sweep: tw_step = 1, samples (k·256, 0). Required results:
  - k = 1 → (181, −181); k = 2 → (0, −512); k = 3 → (−543, −543); k = 4 → (−1024, 0)
  - k = 7 → (1267, 1267)
- Floor behaviour: tw_step = 1, sample 1 = (−1, 0) → (−1, 0). Sample 5 (e = 5) = (1, 0) → (−1, 0).
- Backpressure: out_ready toggles 1,0,0,1 repeating, and in_valid has random gaps. Required: data stable under stall, no loss or duplication, in_ready = 0 until the 8th output handshake.
- flush in MUL at i = 3, then a new frame: no out_valid for the aborted frame. The new frame's results are correct and tw_step is re-latched.
- Async rst asserted mid-UNLOAD at j = 4: outputs return to their reset values immediately. After release, a normal frame completes correctly.
